// File: rtl/tuser_in_fsm_pkg.sv
// Shared types and default widths for the TUSER ingress shim.
package tuser_in_fsm_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 256;
    localparam int unsigned KEEP_WIDTH_DEF  = 32;
    localparam int unsigned TUSER_WIDTH_DEF = 128;
    localparam int unsigned STATE_WIDTH     = 3;

    localparam logic [STATE_WIDTH-1:0] ST_INIT_ENC = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_IDLE_ENC = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_BODY_ENC = 3'd2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_INIT = ST_INIT_ENC,
        ST_IDLE = ST_IDLE_ENC,
        ST_BODY = ST_BODY_ENC
    } state_e;

endpackage

// File: rtl/tuser_in_fsm_if.sv
// AXI4-Stream ingress (A) and egress (B) bundle around the shim.
interface tuser_in_fsm_if #(
    parameter int unsigned DATA_WIDTH  = tuser_in_fsm_pkg::DATA_WIDTH_DEF,
    parameter int unsigned KEEP_WIDTH  = tuser_in_fsm_pkg::KEEP_WIDTH_DEF,
    parameter int unsigned TUSER_WIDTH = tuser_in_fsm_pkg::TUSER_WIDTH_DEF
);
    logic                   tin_avalid;
    logic                   tin_aready;
    logic [DATA_WIDTH-1:0]  tin_adata;
    logic [KEEP_WIDTH-1:0]  tin_akeep;
    logic                   tin_atlast;
    logic [TUSER_WIDTH-1:0] tin_atuser;

    logic                   tin_bvalid;
    logic                   tin_bready;
    logic [DATA_WIDTH-1:0]  tin_bdata;
    logic [KEEP_WIDTH-1:0]  tin_bkeep;
    logic                   tin_btlast;

    // Shim side: sinks stream A, sources stream B.
    modport slave (
        input  tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser, tin_bready,
        output tin_aready, tin_bvalid, tin_bdata, tin_bkeep, tin_btlast
    );

    // Environment side: sources stream A, sinks stream B.
    modport master (
        output tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser, tin_bready,
        input  tin_aready, tin_bvalid, tin_bdata, tin_bkeep, tin_btlast
    );
endinterface

// File: rtl/tuser_in_fsm.sv
// Ingress AXIS shim: forwards A to B unchanged and emits the first-beat TUSER
// of each packet as a one-cycle tuple.
module tuser_in_fsm
    import tuser_in_fsm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned KEEP_WIDTH  = KEEP_WIDTH_DEF,
    parameter int unsigned TUSER_WIDTH = TUSER_WIDTH_DEF
) (
    input  logic                   tin_aclk,
    input  logic                   tin_arst,
    tuser_in_fsm_if.slave          axis,
    output logic                   tin_valid,
    output logic [TUSER_WIDTH-1:0] tin_data,
    output logic [STATE_WIDTH-1:0] dbg_state
);

    state_e                 state_q, state_d;
    logic                   tin_valid_q, tin_valid_d;
    logic [TUSER_WIDTH-1:0] tin_data_q, tin_data_d;
    logic                   pass_c;
    logic                   accept_c;

    // Zero-latency pass-through, gated off while initialising or in an illegal state.
    always_comb begin
        pass_c          = (state_q == ST_IDLE) || (state_q == ST_BODY);
        axis.tin_bvalid = pass_c & axis.tin_avalid;
        axis.tin_aready = pass_c & axis.tin_bready;
        axis.tin_bdata  = DATA_WIDTH'(axis.tin_adata);
        axis.tin_bkeep  = KEEP_WIDTH'(axis.tin_akeep);
        axis.tin_btlast = axis.tin_atlast;
        accept_c        = pass_c & axis.tin_avalid & axis.tin_bready;
    end

    always_comb begin
        state_d     = state_q;
        tin_valid_d = 1'b0;
        tin_data_d  = tin_data_q;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (accept_c) begin
                    tin_valid_d = 1'b1;
                    tin_data_d  = TUSER_WIDTH'(axis.tin_atuser);
                    if (!axis.tin_atlast) state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                if (accept_c && axis.tin_atlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge tin_aclk or negedge tin_arst) begin
        if (!tin_arst) begin
            state_q     <= ST_INIT;
            tin_valid_q <= 1'b0;
            tin_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tin_valid_q <= tin_valid_d;
            tin_data_q  <= tin_data_d;
        end
    end

    assign tin_valid = tin_valid_q;
    assign tin_data  = tin_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Directed self-checking bench for tuser_in_fsm.
module tb_tuser_in_fsm;
    import tuser_in_fsm_pkg::*;

    localparam int unsigned DW = DATA_WIDTH_DEF;
    localparam int unsigned KW = KEEP_WIDTH_DEF;
    localparam int unsigned TW = TUSER_WIDTH_DEF;

    logic          clk;
    logic          rst_n;
    logic          tin_valid;
    logic [TW-1:0] tin_data;
    logic [2:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int pulses;

    tuser_in_fsm_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(TW)) bus ();

    tuser_in_fsm #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(TW)) dut (
        .tin_aclk  (clk),
        .tin_arst  (rst_n),
        .axis      (bus.slave),
        .tin_valid (tin_valid),
        .tin_data  (tin_data),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                         input logic l, input logic [TW-1:0] u);
        bus.tin_avalid = v;
        bus.tin_adata  = d;
        bus.tin_akeep  = k;
        bus.tin_atlast = l;
        bus.tin_atuser = u;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.tin_bready = 1'b1;
        drive(1'b1, DW'(1), KW'(1), 1'b0, TW'(99));

        // Reset: outputs held at reset values even with valid/ready asserted.
        tick();
        tick();
        chk("rst_state",  256'(dbg_state), 256'(0));
        chk("rst_aready", 256'(bus.tin_aready), 256'(0));
        chk("rst_bvalid", 256'(bus.tin_bvalid), 256'(0));
        chk("rst_valid",  256'(tin_valid), 256'(0));
        chk("rst_data",   256'(tin_data), 256'(0));

        drive(1'b0, '0, '0, 1'b0, '0);
        rst_n = 1'b1;
        #1;
        chk("init_state",  256'(dbg_state), 256'(0));
        chk("init_aready", 256'(bus.tin_aready), 256'(0));
        tick();
        chk("idle_state", 256'(dbg_state), 256'(1));

        // Two-beat packet.
        drive(1'b1, DW'(22222), KW'(33333), 1'b0, TW'(44444));
        #1;
        chk("b1_bdata",  256'(bus.tin_bdata), 256'(22222));
        chk("b1_bkeep",  256'(bus.tin_bkeep), 256'(KW'(33333)));
        chk("b1_bvalid", 256'(bus.tin_bvalid), 256'(1));
        chk("b1_btlast", 256'(bus.tin_btlast), 256'(0));
        chk("b1_aready", 256'(bus.tin_aready), 256'(1));
        tick();
        chk("b1_valid", 256'(tin_valid), 256'(1));
        chk("b1_data",  256'(tin_data), 256'(44444));
        chk("b1_state", 256'(dbg_state), 256'(2));
        drive(1'b1, DW'(22223), KW'(33333), 1'b1, TW'(12345));
        #1;
        chk("b2_bdata",  256'(bus.tin_bdata), 256'(22223));
        chk("b2_btlast", 256'(bus.tin_btlast), 256'(1));
        tick();
        chk("b2_valid", 256'(tin_valid), 256'(0));
        chk("b2_data",  256'(tin_data), 256'(44444));
        chk("b2_state", 256'(dbg_state), 256'(1));

        // Ten packets with a two-cycle idle gap; body beats carry a decoy TUSER.
        drive(1'b0, '0, '0, 1'b0, '0);
        pulses = 0;
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 4; c++) begin
                case (c)
                    0:       drive(1'b1, DW'(22222), KW'(33333), 1'b0, TW'(44444));
                    1:       drive(1'b1, DW'(22222), KW'(33333), 1'b1, TW'(777));
                    default: drive(1'b0, DW'(0), KW'(0), 1'b0, TW'(888));
                endcase
                #1;
                chk("loop_aready", 256'(bus.tin_aready), 256'(1));
                tick();
                if (tin_valid) begin
                    pulses++;
                    chk("loop_data", 256'(tin_data), 256'(44444));
                end
            end
        end
        chk("loop_pulses", 256'(pulses), 256'(10));
        chk("loop_state",  256'(dbg_state), 256'(1));

        // Backpressure: no capture while stalled.
        bus.tin_bready = 1'b0;
        drive(1'b1, DW'(5555), KW'(1), 1'b0, TW'(7));
        #1;
        chk("bp_aready", 256'(bus.tin_aready), 256'(0));
        tick();
        chk("bp_valid1", 256'(tin_valid), 256'(0));
        chk("bp_state1", 256'(dbg_state), 256'(1));
        tick();
        chk("bp_valid2", 256'(tin_valid), 256'(0));
        chk("bp_data",   256'(tin_data), 256'(44444));
        bus.tin_bready = 1'b1;
        tick();
        chk("bp_cap_valid", 256'(tin_valid), 256'(1));
        chk("bp_cap_data",  256'(tin_data), 256'(7));
        chk("bp_cap_state", 256'(dbg_state), 256'(2));
        drive(1'b1, DW'(5556), KW'(1), 1'b1, TW'(0));
        tick();
        chk("bp_end_valid", 256'(tin_valid), 256'(0));
        chk("bp_end_state", 256'(dbg_state), 256'(1));

        // Back-to-back single-beat packets.
        drive(1'b1, DW'(1), KW'(1), 1'b1, TW'(5));
        tick();
        chk("sb1_valid", 256'(tin_valid), 256'(1));
        chk("sb1_data",  256'(tin_data), 256'(5));
        chk("sb1_state", 256'(dbg_state), 256'(1));
        drive(1'b1, DW'(2), KW'(1), 1'b1, TW'(6));
        tick();
        chk("sb2_valid", 256'(tin_valid), 256'(1));
        chk("sb2_data",  256'(tin_data), 256'(6));
        chk("sb2_state", 256'(dbg_state), 256'(1));
        drive(1'b0, '0, '0, 1'b0, TW'(3));
        tick();
        chk("sb_idle_valid", 256'(tin_valid), 256'(0));
        chk("sb_idle_data",  256'(tin_data), 256'(6));

        // Reset mid-packet, then the next accepted beat is a start of packet.
        drive(1'b1, DW'(9), KW'(1), 1'b0, TW'(8));
        tick();
        chk("mid_state", 256'(dbg_state), 256'(2));
        drive(1'b1, DW'(10), KW'(1), 1'b1, TW'(9));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state",  256'(dbg_state), 256'(0));
        chk("mid_rst_data",   256'(tin_data), 256'(0));
        chk("mid_rst_valid",  256'(tin_valid), 256'(0));
        chk("mid_rst_aready", 256'(bus.tin_aready), 256'(0));
        chk("mid_rst_bvalid", 256'(bus.tin_bvalid), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_state", 256'(dbg_state), 256'(1));
        chk("mid_rel_valid", 256'(tin_valid), 256'(0));
        tick();
        chk("mid_sop_valid", 256'(tin_valid), 256'(1));
        chk("mid_sop_data",  256'(tin_data), 256'(9));
        chk("mid_sop_state", 256'(dbg_state), 256'(1));
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();
        chk("final_valid", 256'(tin_valid), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tuser_in_fsm.md
Name: tuser_in_fsm

Overview:
- Ingress-side AXI4-Stream shim placed in front of the packet-processing pipeline.
- Forwards every beat of stream A unchanged to stream B.
- On the first beat of each packet, captures the side-band TUSER word and presents it once on a tuple output port (one-cycle valid pulse).
- Exposes its FSM state on a debug port.

Parameters:
DATA_WIDTH, 256, width of tin_adata / tin_bdata
KEEP_WIDTH, 32, width of tin_akeep / tin_bkeep (DATA_WIDTH/8)
TUSER_WIDTH, 128, width of tin_atuser and tin_data

Ports:
tin_aclk  in  1  clock; all logic is rising-edge
tin_arst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release
tin_avalid  in  1  AXIS input valid
tin_aready  out  1  AXIS input ready
tin_adata  in  DATA_WIDTH  AXIS input data
tin_akeep  in  KEEP_WIDTH  AXIS input byte enables
tin_atlast  in  1  AXIS input end of packet
tin_atuser  in  TUSER_WIDTH  side-band metadata; sampled on first beat only
tin_bvalid  out  1  AXIS output valid
tin_bready  in  1  AXIS output ready
tin_bdata  out  DATA_WIDTH  AXIS output data
tin_bkeep  out  KEEP_WIDTH  AXIS output byte enables
tin_btlast  out  1  AXIS output end of packet
tin_valid  out  1  tuple valid, single-cycle pulse per packet
tin_data  out  TUSER_WIDTH  tuple data (captured TUSER)
dbg_state  out  3  current FSM state encoding

Behaviour:
- States and encoding:
  - ST_INIT = 3'd0
  - ST_IDLE = 3'd1 (waiting for start of packet)
  - ST_BODY = 3'd2 (inside packet)
  - Remaining encodings are illegal and recover to ST_IDLE on the next clock.
- Reset (tin_arst=0, asynchronous), required values:
  - state = ST_INIT, dbg_state = 0
  - tin_valid = 0, tin_data = 0
  - tin_aready = 0, tin_bvalid = 0
- ST_INIT: held for exactly one clock after reset release; tin_aready = 0 and tin_bvalid = 0; then goes to ST_IDLE unconditionally.
- ST_IDLE and ST_BODY, combinational pass-through with zero latency:
  - tin_bvalid = tin_avalid
  - tin_bdata = tin_adata
  - tin_bkeep = tin_akeep
  - tin_btlast = tin_atlast
  - tin_aready = tin_bready
- Handshake: a beat is accepted when tin_avalid & tin_aready. No beat is ever dropped, duplicated or reordered. Backpressure from tin_bready propagates directly to tin_aready.
- ST_IDLE, on an accepted beat:
  - Register tin_atuser into tin_data.
  - Assert tin_valid for exactly the next clock cycle (registered, latency 1 from the handshake edge).
  - If tin_atlast=1 (single-beat packet), stay in ST_IDLE; otherwise go to ST_BODY.
- ST_BODY, on an accepted beat: tin_atuser is ignored. If tin_atlast=1, go to ST_IDLE.
- tin_data holds its value until the next start of packet; tin_valid is 0 at all other times.
- Valid without ready (stall) causes no state change and no tuple capture. tin_avalid=0 beats are ignored in any state.
- Back-to-back packets: a start-of-packet beat in the cycle immediately after a tlast beat is captured normally, so consecutive tin_valid pulses are allowed.
- Reset asserted mid-packet: all outputs return to reset values immediately; the partial packet is abandoned. After release the block re-enters ST_INIT, and the next accepted beat is treated as a start of packet.

Decomposition:
- Shared package holds:
  - state encodings ST_INIT, ST_IDLE, ST_BODY as 3-bit localparams
  - default widths: 256/32/128
- Single module, no sub-modules. The tuple capture register is inline.

Test Plan:
- Reset: hold tin_arst=0 for 2 cycles -> dbg_state=0, tin_aready=0, tin_valid=0, tin_data=0; one cycle after release dbg_state=1.
- Two-beat packet: tin_bready=1; beat 1 with adata=22222, akeep=33333, atuser=44444, tlast=0; beat 2 with tlast=1 -> tin_bdata/bkeep mirror each beat; tin_valid=1 for one cycle after beat 1 with tin_data=44444; dbg_state 1 -> 2 -> 1.
- Ten consecutive packets, same stimulus with a 2-cycle idle gap -> exactly 10 tin_valid pulses, tin_data=44444 each time, tin_aready high whenever tin_bready high outside ST_INIT.
- Backpressure: tin_bready=0 with tin_avalid=1, atuser=7 -> tin_aready=0, no tin_valid, state unchanged. Raise tin_bready -> single capture, tin_data=7.
- Single-beat packet (tlast=1 on first beat, atuser=5), then an immediate second SOP (atuser=6) -> two tin_valid pulses on consecutive cycles (5 then 6); state stays 1.
- Reset mid-packet while in ST_BODY -> outputs go to reset values asynchronously; the next packet's first beat is captured as SOP.
